// File: rtl/ft_halt_responder_pkg.sv
// Shared types and default widths for the fault-tolerance halt/resume responder
// and the FT controller it talks to.
package ft_pkg;

  localparam int FT_ADDR_WIDTH    = 5;
  localparam int FT_DATA_WIDTH    = 32;
  localparam int FT_DRAIN_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_RESTORE_PC,
    ST_RESTORE_GPR,
    ST_RESTORE_LAST,
    ST_HALTED,
    ST_RESUME
  } ft_resp_state_t;

  function automatic int num_reg(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ft_halt_responder_if.sv
// Bundle of FT-controller, shadow-register-file and core-side signals seen by
// the halt responder; slave is the responder, master is everything around it.
interface ft_halt_responder_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
);

  logic                  halt_req_i;
  logic                  resume_req_i;
  logic                  core_idle_i;
  logic [DATA_WIDTH-1:0] spc_i;
  logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
  logic [DATA_WIDTH-1:0] sgpr_rdata_i;
  logic                  core_halt_o;
  logic                  pc_set_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic                  halted_o;
  logic                  timeout_o;

  modport slave (
    input  halt_req_i, resume_req_i, core_idle_i, spc_i, sgpr_rdata_i,
    output sgpr_raddr_o, core_halt_o, pc_set_o, pc_o, rf_we_o, rf_waddr_o,
           rf_wdata_o, halted_o, timeout_o
  );

  modport master (
    output halt_req_i, resume_req_i, core_idle_i, spc_i, sgpr_rdata_i,
    input  sgpr_raddr_o, core_halt_o, pc_set_o, pc_o, rf_we_o, rf_waddr_o,
           rf_wdata_o, halted_o, timeout_o
  );

endinterface

// File: rtl/ft_halt_responder_drain.sv
// Pipeline-drain watchdog: counts DRAIN cycles and reports either a clean
// drain (core idle) or expiry after DRAIN_TIMEOUT cycles.
module ft_drain_timer
  import ft_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = FT_DRAIN_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic run_i,
  input  logic idle_i,
  output logic done_o,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             expired;

  assign expired = (cnt_q == LAST_CNT);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (run_i && !idle_i && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A core that goes idle on the final counted cycle is a clean drain.
  assign done_o    = run_i && (idle_i || expired);
  assign timeout_o = run_i && !idle_i && expired;

endmodule

// File: rtl/ft_halt_responder.sv
// Core-side halt/resume responder: stalls the core, waits for drain, restores
// PC and GPRs 1..NUM_REG-1 from the shadow copy, then holds until resumed.
module ft_halt_responder
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH    = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = FT_DATA_WIDTH,
  parameter int DRAIN_TIMEOUT = FT_DRAIN_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ft_halt_responder_if.slave  bus
);

  localparam int NUM_REG = num_reg(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PRELAST = ADDR_WIDTH'(NUM_REG - 2);

  ft_resp_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic                  timeout_q, timeout_d;
  logic                  core_halt_q, halted_q;
  logic                  drain_start, drain_done, drain_timeout;
  logic                  pc_set, rf_we;
  logic [ADDR_WIDTH-1:0] raddr;

  ft_drain_timer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (drain_start),
    .run_i     (state_q == ST_DRAIN),
    .idle_i    (bus.core_idle_i),
    .done_o    (drain_done),
    .timeout_o (drain_timeout)
  );

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    timeout_d   = timeout_q;
    drain_start = 1'b0;
    pc_set      = 1'b0;
    rf_we       = 1'b0;
    raddr       = '0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.halt_req_i) begin
          state_d     = ST_DRAIN;
          timeout_d   = 1'b0;
          drain_start = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_RESTORE_PC;
          if (drain_timeout) timeout_d = 1'b1;
        end
      end
      ST_RESTORE_PC: begin
        pc_set  = 1'b1;
        raddr   = ADDR_FIRST;
        addr_d  = ADDR_FIRST;
        state_d = (NUM_REG == 2) ? ST_RESTORE_LAST : ST_RESTORE_GPR;
      end
      ST_RESTORE_GPR: begin
        rf_we  = 1'b1;
        raddr  = addr_q + 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_PRELAST) state_d = ST_RESTORE_LAST;
      end
      ST_RESTORE_LAST: begin
        // Read address parks on the top register instead of wrapping to x0.
        rf_we   = 1'b1;
        raddr   = addr_q;
        state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (bus.resume_req_i || pend_q) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // An early resume is remembered so HALTED is still visible for one cycle.
    if (bus.resume_req_i && (state_q inside {ST_DRAIN, ST_RESTORE_PC,
                                             ST_RESTORE_GPR, ST_RESTORE_LAST}))
      pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      timeout_q   <= 1'b0;
      core_halt_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      timeout_q   <= timeout_d;
      core_halt_q <= (state_d != ST_RUN);
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  assign bus.core_halt_o  = core_halt_q;
  assign bus.halted_o     = halted_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.pc_set_o     = pc_set;
  assign bus.pc_o         = pc_set ? bus.spc_i : {DATA_WIDTH{1'b0}};
  assign bus.rf_we_o      = rf_we;
  assign bus.rf_waddr_o   = rf_we ? addr_q : '0;
  assign bus.rf_wdata_o   = rf_we ? bus.sgpr_rdata_i : {DATA_WIDTH{1'b0}};
  assign bus.sgpr_raddr_o = raddr;

endmodule

// File: tb/tb_ft_halt_responder.sv
// Directed bench for ft_halt_responder: nominal restore, drain timeout, early
// resume, halt+resume collision, spurious requests and reset mid-restore.
module tb_ft_halt_responder;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  ft_halt_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ft_halt_responder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DRAIN_TIMEOUT (16)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Shadow register file: entry k holds 0xA000_0000 + k, one-cycle read latency.
  always @(posedge clk_i) bus.sgpr_rdata_i <= 32'hA000_0000 + 32'(bus.sgpr_raddr_o);

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Mid-cycle monitor of the core-side write port and status outputs.
  int   wr_cnt = 0, pc_cnt = 0, halted_cnt = 0;
  int   addr_err = 0, data_err = 0, x0_wr = 0;
  int   req_cyc = 0, pc_cyc = 0, rise_cyc = 0, last_wr_cyc = 0;
  int   exp_addr = 1;
  logic [DW-1:0] pc_val = '0;
  logic halted_prev = 1'b0;

  always @(negedge clk_i) begin
    if (bus.halt_req_i) req_cyc <= cyc;
    if (bus.pc_set_o) begin
      pc_cnt   <= pc_cnt + 1;
      pc_val   <= bus.pc_o;
      pc_cyc   <= cyc;
      exp_addr <= 1;
    end
    if (bus.rf_we_o) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
      exp_addr    <= exp_addr + 1;
      if (bus.rf_waddr_o == '0) x0_wr <= x0_wr + 1;
      if (int'(bus.rf_waddr_o) != exp_addr) addr_err <= addr_err + 1;
      if (bus.rf_wdata_o != 32'hA000_0000 + 32'(bus.rf_waddr_o)) data_err <= data_err + 1;
    end
    if (bus.halted_o) halted_cnt <= halted_cnt + 1;
    if (bus.halted_o && !halted_prev) rise_cyc <= cyc;
    halted_prev <= bus.halted_o;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse(input logic halt, input logic resume);
    bus.halt_req_i   = halt;
    bus.resume_req_i = resume;
    step();
    bus.halt_req_i   = 1'b0;
    bus.resume_req_i = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!bus.halted_o && n < 100) begin
      step();
      n++;
    end
    check(tag, 64'(bus.halted_o), 64'd1);
  endtask

  task automatic wait_write(input string tag, input int addr);
    int n = 0;
    while (!(bus.rf_we_o && int'(bus.rf_waddr_o) == addr) && n < 100) begin
      step();
      n++;
    end
    check(tag, 64'(bus.rf_waddr_o), 64'(addr));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_halt"},   64'(bus.core_halt_o),  64'd0);
    check({tag, "_pcset"},  64'(bus.pc_set_o),     64'd0);
    check({tag, "_pc"},     64'(bus.pc_o),         64'd0);
    check({tag, "_we"},     64'(bus.rf_we_o),      64'd0);
    check({tag, "_waddr"},  64'(bus.rf_waddr_o),   64'd0);
    check({tag, "_wdata"},  64'(bus.rf_wdata_o),   64'd0);
    check({tag, "_raddr"},  64'(bus.sgpr_raddr_o), 64'd0);
    check({tag, "_halted"}, 64'(bus.halted_o),     64'd0);
  endtask

  int w0, p0, h0;

  initial begin
    bus.halt_req_i   = 1'b0;
    bus.resume_req_i = 1'b0;
    bus.core_idle_i  = 1'b1;
    bus.spc_i        = 32'h0000_0100;

    // Reset state
    step(2);
    check_quiet("rst");
    check("rst_timeout", 64'(bus.timeout_o), 64'd0);
    rst_i = 1'b0;
    step(2);

    // Nominal restore with the core already idle
    w0 = wr_cnt; p0 = pc_cnt;
    pulse(1'b1, 1'b0);
    check("nom_core_halt", 64'(bus.core_halt_o), 64'd1);
    wait_halted("nom_wait_halted");
    step(3);
    check("nom_still_halted", 64'(bus.halted_o), 64'd1);
    check("nom_writes", 64'(wr_cnt - w0), 64'd31);
    check("nom_pc_sets", 64'(pc_cnt - p0), 64'd1);
    check("nom_pc_val", 64'(pc_val), 64'h100);
    check("nom_pc_lat", 64'(pc_cyc - req_cyc), 64'd2);
    check("nom_last_wr", 64'(last_wr_cyc - pc_cyc), 64'd31);
    check("nom_halted_lat", 64'(rise_cyc - req_cyc), 64'd34);
    check("nom_timeout", 64'(bus.timeout_o), 64'd0);
    pulse(1'b0, 1'b1);
    check("nom_resume_hold", 64'(bus.core_halt_o), 64'd1);
    check("nom_resume_unhalted", 64'(bus.halted_o), 64'd0);
    step();
    check("nom_released", 64'(bus.core_halt_o), 64'd0);

    // Drain timeout: core never idles
    bus.core_idle_i = 1'b0;
    w0 = wr_cnt;
    pulse(1'b1, 1'b0);
    wait_halted("to_wait_halted");
    step(2);
    check("to_pc_lat", 64'(pc_cyc - req_cyc), 64'd17);
    check("to_timeout", 64'(bus.timeout_o), 64'd1);
    check("to_writes", 64'(wr_cnt - w0), 64'd31);
    bus.core_idle_i = 1'b1;
    pulse(1'b0, 1'b1);
    step(2);
    check("to_released", 64'(bus.core_halt_o), 64'd0);
    check("to_sticky", 64'(bus.timeout_o), 64'd1);

    // Early resume during the GPR replay
    w0 = wr_cnt; h0 = halted_cnt;
    pulse(1'b1, 1'b0);
    check("er_timeout_clr", 64'(bus.timeout_o), 64'd0);
    wait_write("er_wait_wr10", 10);
    pulse(1'b0, 1'b1);
    wait_halted("er_wait_halted");
    step();
    check("er_halted_drop", 64'(bus.halted_o), 64'd0);
    check("er_resume_hold", 64'(bus.core_halt_o), 64'd1);
    step();
    check("er_released", 64'(bus.core_halt_o), 64'd0);
    check("er_halted_cycles", 64'(halted_cnt - h0), 64'd1);
    check("er_writes", 64'(wr_cnt - w0), 64'd31);

    // Halt and resume together: resume dropped, HALTED waits
    pulse(1'b1, 1'b1);
    wait_halted("hr_wait_halted");
    step(5);
    check("hr_still_halted", 64'(bus.halted_o), 64'd1);

    // Spurious halt while halted
    w0 = wr_cnt; p0 = pc_cnt;
    pulse(1'b1, 1'b0);
    step(3);
    check("sp_halt_writes", 64'(wr_cnt - w0), 64'd0);
    check("sp_halt_pcset", 64'(pc_cnt - p0), 64'd0);
    check("sp_halt_halted", 64'(bus.halted_o), 64'd1);
    pulse(1'b0, 1'b1);
    step();
    check("sp_released", 64'(bus.core_halt_o), 64'd0);

    // Spurious resume while running
    w0 = wr_cnt;
    pulse(1'b0, 1'b1);
    step(3);
    check("sp_res_halt", 64'(bus.core_halt_o), 64'd0);
    check("sp_res_halted", 64'(bus.halted_o), 64'd0);
    check("sp_res_writes", 64'(wr_cnt - w0), 64'd0);

    // Reset in the middle of the GPR replay, then a fresh full replay
    pulse(1'b1, 1'b0);
    wait_write("rm_wait_wr5", 5);
    rst_i = 1'b1;
    #1;
    check_quiet("rm");
    step();
    rst_i = 1'b0;
    step();
    w0 = wr_cnt;
    pulse(1'b1, 1'b0);
    wait_halted("rm_wait_halted");
    step(2);
    check("rm_writes", 64'(wr_cnt - w0), 64'd31);
    pulse(1'b0, 1'b1);
    step(2);
    check("rm_released", 64'(bus.core_halt_o), 64'd0);

    check("x0_never_written", 64'(x0_wr), 64'd0);
    check("write_order", 64'(addr_err), 64'd0);
    check("write_data", 64'(data_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ft_halt_responder.md
Name: ft_halt_responder

Overview:
- Core-side responder to the fault-tolerance controller's halt/resume protocol.
- On a halt request it stalls the core and waits for the pipeline to drain (with a timeout). It then restores the PC from the shadow PC and replays every GPR from the shadow register file into the core register file.
- It then reports halted and holds the core until a resume request releases it.
- Sits between the FT controller, the shadow register file (read port) and the core's register-file write port / PC-set interface.

Parameters:
- ADDR_WIDTH, 5, register-file address width; NUM_REG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register and PC width.
- DRAIN_TIMEOUT, 16, max cycles waiting for core_idle_i before forcing restore; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- halt_req_i  in  1  single-cycle halt request from the FT controller.
- resume_req_i  in  1  single-cycle resume request from the FT controller.
- core_idle_i  in  1  core pipeline drained, no outstanding memory access.
- spc_i  in  DATA_WIDTH  shadow PC value.
- sgpr_raddr_o  out  ADDR_WIDTH  shadow GPR read address; data returns one cycle later.
- sgpr_rdata_i  in  DATA_WIDTH  shadow GPR read data.
- core_halt_o  out  1  stall fetch/issue.
- pc_set_o  out  1  load pc_o into the core PC this cycle.
- pc_o  out  DATA_WIDTH  PC restore value.
- rf_we_o  out  1  core register-file write enable.
- rf_waddr_o  out  ADDR_WIDTH  core register-file write address.
- rf_wdata_o  out  DATA_WIDTH  core register-file write data.
- halted_o  out  1  restore complete, core held.
- timeout_o  out  1  sticky: the last drain ended by timeout; cleared on the next halt acceptance.

Behaviour:
- Reset (asynchronous, any state):
  - state=RUN.
  - All outputs 0: core_halt_o, pc_set_o, rf_we_o, halted_o, timeout_o, sgpr_raddr_o, rf_waddr_o, rf_wdata_o, pc_o.
  - Drain counter, address counter and resume_pending all 0.
- States: RUN, DRAIN, RESTORE_PC, RESTORE_GPR, RESTORE_LAST, HALTED, RESUME.
- RUN:
  - halt_req_i=1 -> DRAIN, clear timeout_o, drain counter=0.
  - core_halt_o is registered high from the next cycle and stays high until RESUME exits.
  - halt_req_i and resume_req_i in the same cycle: halt wins, the resume is dropped.
  - resume_req_i alone is ignored.
- DRAIN:
  - core_idle_i=1 -> RESTORE_PC.
  - Otherwise the counter increments. When counter == DRAIN_TIMEOUT-1 and core_idle_i=0 -> RESTORE_PC with timeout_o<=1.
- RESTORE_PC (1 cycle):
  - pc_set_o=1, pc_o=spc_i.
  - sgpr_raddr_o=1 is presented this cycle, pre-fetching the first read.
  - -> RESTORE_GPR, address counter=1.
- RESTORE_GPR:
  - Each cycle rf_we_o=1, rf_waddr_o=addr, rf_wdata_o=sgpr_rdata_i, and sgpr_raddr_o=addr+1.
  - Address x0 is never written.
  - When addr==NUM_REG-2 the next state is RESTORE_LAST.
  - The counter never wraps: sgpr_raddr_o must not present 0 after NUM_REG-1.
- RESTORE_LAST (1 cycle):
  - Writes address NUM_REG-1 -> HALTED.
  - Total: NUM_REG-1 writes on consecutive cycles, addresses 1..NUM_REG-1 ascending.
- HALTED:
  - halted_o=1 (registered, asserted the cycle the state is entered).
  - resume_req_i=1 or resume_pending=1 -> RESUME.
- RESUME (1 cycle):
  - halted_o=0 and core_halt_o=0 from the next cycle.
  - resume_pending cleared -> RUN.
- resume_req_i during DRAIN/RESTORE_*:
  - Latched in resume_pending.
  - HALTED is still entered for exactly one cycle with halted_o=1, then RESUME.
- halt_req_i outside RUN is ignored; there is no nested halt.
- Strobes (pc_set_o, rf_we_o) are high only in the stated states; all other cycles are 0.
- rf_waddr_o, rf_wdata_o and pc_o may hold stale values when their strobes are low.
- Minimum halt-to-halted latency with core_idle_i already high:
  - 1 cycle DRAIN + 1 cycle RESTORE_PC + NUM_REG-1 write cycles; halted_o is high at cycle NUM_REG+2 after the halt request (34 for ADDR_WIDTH=5).
- Reset mid-restore: immediate return to RUN. The partial register-file contents are not rolled back.

Decomposition:
- Package ft_pkg holds:
  - the state enum typedef ft_resp_state_t;
  - localparam NUM_REG derivation helper;
  - default widths shared with the FT controller (ADDR_WIDTH, DATA_WIDTH).
- One sub-module, ft_drain_timer: the drain counter with start/clear/idle inputs and done/timeout outputs.
- The rest is flat.

Test Plan:
- Nominal, core_idle_i tied 1:
  - Stimulus: pulse halt_req_i; spc_i=0x0000_0100; shadow reg k holds 0xA000_0000+k.
  - Response: pc_set_o one cycle with pc_o=0x100, then 31 writes with rf_waddr_o=1..31 and rf_wdata_o=0xA000_0001..0xA000_001F. halted_o high at cycle 34; timeout_o=0.
  - Then resume_req_i -> core_halt_o=0 two cycles later.
- Drain timeout:
  - Stimulus: core_idle_i=0 forever, DRAIN_TIMEOUT=16.
  - Response: pc_set_o exactly 16 cycles after DRAIN entry; timeout_o=1 and stays 1 until the next halt.
- Early resume:
  - Stimulus: resume_req_i pulsed during RESTORE_GPR at addr=10.
  - Response: all 31 writes complete, halted_o high exactly 1 cycle, RUN follows with no further request.
- Simultaneous halt+resume in RUN:
  - Response: halt taken; the later HALTED state waits for a new resume_req_i.
- Spurious requests:
  - Stimulus: resume_req_i in RUN; halt_req_i in HALTED.
  - Response: no state change, no register writes.
- Reset mid-operation:
  - Stimulus: rst_i asserted at RESTORE_GPR addr=5.
  - Response: same-cycle outputs all 0, no write to x0 at any point; a fresh halt afterwards performs a full 31-write replay.
